// File: rtl/pool_window_sequencer.sv
// Flow-control sequencer for a streaming pooling layer: gates the layer clock on accepted
// pixels, picks the strided window positions and holds each pooled result for downstream.
module pool_window_sequencer #(
  parameter int IMAGE_SIZE  = 28,
  parameter int FILTER_SIZE = 2,
  parameter int STRIDE      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  output logic layer_clk_en,
  input  logic layer_valid,
  output logic capture_en,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic frame_done,
  input  logic soft_clear
);

  localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] POS_MAX   = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] POS_FIRST = CW'(FILTER_SIZE - 1);
  localparam logic [PW-1:0] PHASE_MAX = PW'(STRIDE - 1);

  logic [CW-1:0] col, row, col_next, row_next;
  logic [PW-1:0] col_phase, row_phase, col_phase_next, row_phase_next;
  logic          accept, selected, col_wrap, row_wrap;

  assign in_ready     = rst_n & ~soft_clear & (~out_valid | out_ready);
  assign accept       = in_valid & in_ready;
  assign layer_clk_en = accept;

  assign col_wrap = (col == POS_MAX);
  assign row_wrap = (row == POS_MAX);

  assign selected = accept & layer_valid & (row >= POS_FIRST) & (col >= POS_FIRST)
                  & (col_phase == '0) & (row_phase == '0);
  assign capture_en = selected;

  // Phase is re-anchored at the first full window so stride selection needs no divider.
  always_comb begin
    col_next       = col_wrap ? '0 : col + 1'b1;
    row_next       = row_wrap ? '0 : row + 1'b1;
    col_phase_next = (col_phase == PHASE_MAX) ? '0 : col_phase + 1'b1;
    row_phase_next = (row_phase == PHASE_MAX) ? '0 : row_phase + 1'b1;
    if (col_next == POS_FIRST) col_phase_next = '0;
    if (row_next == POS_FIRST) row_phase_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      col_phase  <= '0;
      row_phase  <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else if (soft_clear) begin
      col        <= '0;
      row        <= '0;
      col_phase  <= '0;
      row_phase  <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid & out_ready & out_last;
      if (accept) begin
        col       <= col_next;
        col_phase <= col_phase_next;
        if (col_wrap) begin
          row       <= row_next;
          row_phase <= row_phase_next;
        end
      end
      // A new selection while the old result drains keeps out_valid high back-to-back.
      if (selected) begin
        out_valid <= 1'b1;
        out_last  <= col_wrap & row_wrap;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Directed bench for pool_window_sequencer on a 4x4 image (2x2 window, stride 2) plus a
// 3x3 stride-1 instance where consecutive pixels are both selected.
module tb_pool_window_sequencer;

  logic clk, rst_n;
  logic in_valid, layer_valid, out_ready, soft_clear;
  logic in_ready, layer_clk_en, capture_en, out_valid, out_last, frame_done;
  logic b_in_valid, b_layer_valid, b_out_ready, b_soft_clear;
  logic b_in_ready, b_layer_clk_en, b_capture_en, b_out_valid, b_out_last, b_frame_done;
  int total = 0;
  int bad   = 0;

  pool_window_sequencer #(.IMAGE_SIZE(4), .FILTER_SIZE(2), .STRIDE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .layer_clk_en(layer_clk_en), .layer_valid(layer_valid), .capture_en(capture_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .soft_clear(soft_clear)
  );

  pool_window_sequencer #(.IMAGE_SIZE(3), .FILTER_SIZE(2), .STRIDE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .layer_clk_en(b_layer_clk_en), .layer_valid(b_layer_valid), .capture_en(b_capture_en),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .frame_done(b_frame_done), .soft_clear(b_soft_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", tag, actual, expected, $time);
    end
  endtask

  // Inputs change just after the rising edge; checks happen at the following falling edge.
  task automatic applyStimulus(input logic iv, input logic lv, input logic ordy, input logic sc);
    @(posedge clk);
    #1;
    in_valid    = iv;
    layer_valid = lv;
    out_ready   = ordy;
    soft_clear  = sc;
    @(negedge clk);
  endtask

  function automatic logic isSel4(input int i);
    return (i == 5) || (i == 7) || (i == 13) || (i == 15);
  endfunction

  function automatic logic isSel3(input int i);
    return (i == 4) || (i == 5) || (i == 7) || (i == 8);
  endfunction

  task automatic streamPartial(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // One full 16-pixel frame, optional 3-cycle downstream stall before pixel stallAt,
  // layer_valid low before pixel lvFrom; then drains the final result.
  task automatic runFrame(input int stallAt, input int lvFrom);
    logic prevSel, curSel;
    prevSel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == stallAt) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
          checkOutput("stall_in_ready", in_ready, 1'b0);
          checkOutput("stall_clk_en", layer_clk_en, 1'b0);
          checkOutput("stall_capture", capture_en, 1'b0);
          checkOutput("stall_out_valid", out_valid, 1'b1);
        end
      end
      curSel = isSel4(i) && (i >= lvFrom);
      applyStimulus(1'b1, (i >= lvFrom), 1'b1, 1'b0);
      checkOutput("pix_in_ready", in_ready, 1'b1);
      checkOutput("pix_clk_en", layer_clk_en, 1'b1);
      checkOutput("pix_capture", capture_en, curSel);
      checkOutput("pix_out_valid", out_valid, prevSel);
      checkOutput("pix_out_last", out_last, 1'b0);
      checkOutput("pix_frame_done", frame_done, 1'b0);
      prevSel = curSel;
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("drain_out_valid", out_valid, 1'b1);
    checkOutput("drain_out_last", out_last, 1'b1);
    checkOutput("drain_frame_done", frame_done, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("done_pulse", frame_done, 1'b1);
    checkOutput("done_out_valid", out_valid, 1'b0);
    checkOutput("done_out_last", out_last, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("done_single", frame_done, 1'b0);
  endtask

  initial begin
    logic prevSel;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    layer_valid = 1'b1;
    out_ready   = 1'b1;
    soft_clear  = 1'b0;
    b_in_valid    = 1'b0;
    b_layer_valid = 1'b1;
    b_out_ready   = 1'b1;
    b_soft_clear  = 1'b0;
    #12;
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_clk_en", layer_clk_en, 1'b0);
    checkOutput("rst_capture", capture_en, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_last", out_last, 1'b0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    $display("[TB] plain frame");
    runFrame(-1, 0);
    $display("[TB] downstream stall after first result");
    runFrame(6, 0);
    $display("[TB] layer_valid low for pixels 0-6");
    runFrame(-1, 7);

    $display("[TB] async reset mid-frame");
    streamPartial(8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("prerst_out_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_in_ready", in_ready, 1'b0);
    checkOutput("midrst_clk_en", layer_clk_en, 1'b0);
    checkOutput("midrst_capture", capture_en, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    runFrame(-1, 0);

    $display("[TB] soft_clear with result pending");
    streamPartial(6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("sc_in_ready", in_ready, 1'b0);
    checkOutput("sc_clk_en", layer_clk_en, 1'b0);
    checkOutput("sc_capture", capture_en, 1'b0);
    checkOutput("sc_out_valid_held", out_valid, 1'b1);
    runFrame(-1, 0);

    $display("[TB] stride-1 back-to-back results");
    prevSel = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 b_in_valid = 1'b1;
      @(negedge clk);
      checkOutput("b2b_in_ready", b_in_ready, 1'b1);
      checkOutput("b2b_capture", b_capture_en, isSel3(i));
      checkOutput("b2b_out_valid", b_out_valid, prevSel);
      checkOutput("b2b_out_last", b_out_last, 1'b0);
      prevSel = isSel3(i);
    end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_drain_valid", b_out_valid, 1'b1);
    checkOutput("b2b_drain_last", b_out_last, 1'b1);
    @(negedge clk);
    checkOutput("b2b_frame_done", b_frame_done, 1'b1);
    checkOutput("b2b_out_valid_clr", b_out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
